register_bank_responder: RTL and testbench
==========================================

// Module: register_bank_responder
// PURPOSE
// - Responder end of the machine memory bus: a bank of 2^M registers of N bits (A..D at defaults) that the
//   executor reads and writes over MemorySelect/MemoryData/MemoryRW.
// - Adds a host preload port (valid/ready) for loading programs' initial values, a sequential Clear sweep,
//   and a side-band debug read port. Sits between the executor and the top-level test harness.
// PARAMETERS
// - N  8  bits per register cell
// - M  2  select width; cell count = 2^M; MemorySelect is a binary index
// PORTS
// - Clock         in     1  posedge clock
// - ResetN        in     1  asynchronous, active-low reset
// - MemorySelect  in     M  binary cell index from the executor
// - MemoryData    inout  N  shared data bus; driven by bank only when MemoryRW=0, else high-Z from bank
// - MemoryRW      in     1  0=read (bank drives), 1=write (executor drives)
// - InitValid     in     1  host preload request
// - InitAddr      in     M  host preload cell index
// - InitData      in     N  host preload value
// - InitReady     out    1  preload accepted this cycle when InitValid&InitReady
// - Clear         in     1  1-cycle pulse: start zeroing sweep
// - Busy          out    1  high while Clear sweep runs
// - DebugSelect   in     M  side-band read index
// - DebugData     out    N  cell[DebugSelect], combinational
// BEHAVIOUR
// - Reset (ResetN=0, async): all cells=0, state=IDLE, sweep index=0, Busy=0; InitReady=0 while ResetN=0;
//   MemoryData released (high-Z) while ResetN=0.
// - Read: MemoryRW=0 -> MemoryData = cell[MemorySelect], combinational, zero latency; executor samples it
//   on the next posedge after presenting MemorySelect.
// - Write: MemoryRW=1 -> cell[MemorySelect] <= MemoryData at posedge. Written value visible on read and
//   DebugData the cycle after.
// - InitReady = ResetN & ~MemoryRW & (state==IDLE); combinational. Accepted preload writes
//   cell[InitAddr] <= InitData at that posedge. Executor write always has priority; host holds InitValid.
// - FSM: IDLE -> (Clear) -> SWEEP. SWEEP: cell[idx] <= 0, idx++ each cycle; after idx=2^M-1 -> IDLE, idx=0.
//   Busy = (state==SWEEP), registered with state. Clear while SWEEP ignored (no restart).
// - Executor write during SWEEP is applied; if same cycle idx==MemorySelect, executor value wins
//   (cell keeps written value). Executor reads during SWEEP return current contents.
// - Sweep takes exactly 2^M cycles (4 at defaults); Busy rises the cycle after the Clear posedge.
// - Reset mid-sweep: immediate return to IDLE, all cells 0, Busy=0.
// - Index wrap: idx is M bits; wrap to 0 is the terminal condition, no out-of-range cell.
// - No arithmetic on data; all widths exact N; no truncation/extension.
// STRUCTURE
// - Shared package simple_machine_pkg: default N/M, register index constants REG_A=0..REG_D=3,
//   bank FSM state enum {IDLE, SWEEP}.
// - One natural sub-module: bank_clear_sweeper (FSM, index counter, Busy, per-cycle clear strobe+index).
// - Cell array, write-priority mux and tristate driver stay in the top module.
// TESTING (N=8, M=2)
// - Reset then read: ResetN pulse low, RW=0, Select=2 -> MemoryData=8'h00, Busy=0, InitReady=1.
// - Write/read: RW=1,Select=1,Data=8'h5A one cycle; RW=0,Select=1 -> MemoryData=8'h5A; DebugSelect=1 -> 8'h5A.
// - Preload contention: InitValid=1,InitAddr=3,InitData=8'h33 with RW=1,Select=0,Data=8'h11 ->
//   InitReady=0, cell0=8'h11; next cycle RW=0 -> InitReady=1, cell3=8'h33.
// - Clear sweep: cells=11,22,33,44; Clear pulse -> Busy high 4 cycles, then all cells 8'h00, Busy=0.
// - Sweep collision: during sweep, executor writes 8'hAB to cell2 on the cycle idx==2 -> cell2=8'hAB after sweep.
// - Async reset mid-sweep: ResetN low at sweep idx=1 between clocks -> Busy=0 and all cells 0 immediately.

Source files
------------

// File: rtl/simple_machine_pkg.sv
// ---------------------------------------------------------------------------
// simple_machine_pkg
// Shared definitions for the simple machine memory bus: default register
// width and select width, symbolic register indices, and the state encoding
// used by the register bank's clear sweeper.
// ---------------------------------------------------------------------------
package simple_machine_pkg;

    // Default geometry: 2^2 = 4 registers of 8 bits (A..D).
    localparam int DEFAULT_N = 8;
    localparam int DEFAULT_M = 2;

    // Register indices as seen on MemorySelect.
    localparam logic [DEFAULT_M-1:0] REG_A = 2'd0;
    localparam logic [DEFAULT_M-1:0] REG_B = 2'd1;
    localparam logic [DEFAULT_M-1:0] REG_C = 2'd2;
    localparam logic [DEFAULT_M-1:0] REG_D = 2'd3;

    // Bank FSM state encoding.
    typedef enum logic [0:0] {
        BANK_IDLE  = 1'b0,
        BANK_SWEEP = 1'b1
    } bank_state_e;

endpackage

// File: rtl/bank_clear_sweeper.sv
// ---------------------------------------------------------------------------
// bank_clear_sweeper
// Walks every cell index once after a Clear pulse, issuing one clear strobe
// per cycle. The sweep lasts exactly 2^M cycles; a Clear seen while already
// sweeping is ignored.
//
// Ports
//   clk        in   posedge clock
//   rst_n      in   asynchronous active-low reset
//   i_clear    in   start request (sampled only in IDLE)
//   o_busy     out  high while sweeping (decoded straight from the state reg)
//   o_clr_en   out  clear strobe for cell o_clr_idx this cycle
//   o_clr_idx  out  cell index being cleared
// ---------------------------------------------------------------------------
module bank_clear_sweeper
    import simple_machine_pkg::*;
#(
    parameter int M = DEFAULT_M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    output logic         o_busy,
    output logic         o_clr_en,
    output logic [M-1:0] o_clr_idx
);

    localparam logic [0:0] ST_IDLE  = BANK_IDLE;
    localparam logic [0:0] ST_SWEEP = BANK_SWEEP;
    localparam logic [M-1:0] IDX_LAST = {M{1'b1}};

    logic [0:0]   r_state;
    logic [M-1:0] r_idx;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values; blocking here would create order-dependent
    // simulation that no longer matches the synthesized flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_idx <= '0;
                    if (i_clear) begin
                        r_state <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    // The index wraps to 0 on its own after the last cell,
                    // which leaves it ready for the next sweep.
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign o_busy    = (r_state == ST_SWEEP);
    assign o_clr_en  = o_busy;
    assign o_clr_idx = r_idx;

endmodule

// File: rtl/register_bank_responder.sv
// ---------------------------------------------------------------------------
// register_bank_responder
// Responder end of the machine memory bus: 2^M registers of N bits that the
// executor reads and writes over MemorySelect/MemoryData/MemoryRW, plus a
// host preload port, a sequential Clear sweep and a side-band debug read.
//
// Ports
//   Clock         in     posedge clock
//   ResetN        in     asynchronous active-low reset
//   MemorySelect  in     [M]  executor cell index
//   MemoryData    inout  [N]  shared bus; bank drives only when MemoryRW=0
//   MemoryRW      in     0 = read (bank drives), 1 = write (executor drives)
//   InitValid     in     host preload request
//   InitAddr      in     [M]  host preload cell index
//   InitData      in     [N]  host preload value
//   InitReady     out    preload accepted when InitValid & InitReady
//   Clear         in     1-cycle pulse starting the zeroing sweep
//   Busy          out    high while the sweep runs
//   DebugSelect   in     [M]  side-band read index
//   DebugData     out    [N]  cell[DebugSelect], combinational
// ---------------------------------------------------------------------------
module register_bank_responder
    import simple_machine_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int M = DEFAULT_M
) (
    input  logic         Clock,
    input  logic         ResetN,
    input  logic [M-1:0] MemorySelect,
    inout  wire  [N-1:0] MemoryData,
    input  logic         MemoryRW,
    input  logic         InitValid,
    input  logic [M-1:0] InitAddr,
    input  logic [N-1:0] InitData,
    output logic         InitReady,
    input  logic         Clear,
    output logic         Busy,
    input  logic [M-1:0] DebugSelect,
    output logic [N-1:0] DebugData
);

    localparam int CELLS = 1 << M;

    logic [N-1:0] r_cells [CELLS];

    logic         w_busy;
    logic         w_clr_en;
    logic [M-1:0] w_clr_idx;
    logic         w_init_accept;

    bank_clear_sweeper #(
        .M (M)
    ) u_sweeper (
        .clk       (Clock),
        .rst_n     (ResetN),
        .i_clear   (Clear),
        .o_busy    (w_busy),
        .o_clr_en  (w_clr_en),
        .o_clr_idx (w_clr_idx)
    );

    assign Busy = w_busy;

    // The host may preload only when the executor is not writing and no
    // sweep is running, so a preload never collides with either.
    assign InitReady     = ResetN & ~MemoryRW & ~w_busy;
    assign w_init_accept = InitValid & InitReady;

    // NOTE: the cell array sits on the asynchronous reset because the bank
    // must read as all-zero the moment reset asserts, including mid-sweep;
    // a register file without that requirement would normally skip it.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < CELLS; i++) begin
                r_cells[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CELLS; i++) begin
                // Executor write beats the sweep's clear on the same cell.
                if (MemoryRW && (MemorySelect == M'(i))) begin
                    r_cells[i] <= MemoryData;
                end else if (w_clr_en && (w_clr_idx == M'(i))) begin
                    r_cells[i] <= '0;
                end else if (w_init_accept && (InitAddr == M'(i))) begin
                    r_cells[i] <= InitData;
                end
            end
        end
    end

    // Bus is released during reset and whenever the executor is writing.
    assign MemoryData = (ResetN && !MemoryRW) ? r_cells[MemorySelect] : {N{1'bz}};
    assign DebugData  = r_cells[DebugSelect];

endmodule

// File: tb/tb_register_bank_responder.sv
// ---------------------------------------------------------------------------
// tb_register_bank_responder
// Directed stimulus with hand-computed expectations pushed into a scoreboard
// queue; a monitor pops one entry per observation request and compares the
// DUT outputs at the falling clock edge.
// ---------------------------------------------------------------------------
module tb_register_bank_responder;

    localparam int N = 8;
    localparam int M = 2;

    typedef struct {
        string      name;
        bit         chk_mem;
        logic [7:0] mem;
        bit         chk_dbg;
        logic [7:0] dbg;
        bit         chk_busy;
        logic       busy;
        bit         chk_rdy;
        logic       rdy;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [M-1:0] sel;
    logic         rw;
    logic [N-1:0] drv_val;
    logic         init_valid;
    logic [M-1:0] init_addr;
    logic [N-1:0] init_data;
    logic         init_ready;
    logic         clear;
    logic         busy;
    logic [M-1:0] dbg_sel;
    logic [N-1:0] dbg_data;
    wire  [N-1:0] mem_data;

    // Bench drives the shared bus only for executor writes.
    assign mem_data = rw ? drv_val : {N{1'bz}};

    register_bank_responder #(
        .N (N),
        .M (M)
    ) dut (
        .Clock        (clk),
        .ResetN       (rst_n),
        .MemorySelect (sel),
        .MemoryData   (mem_data),
        .MemoryRW     (rw),
        .InitValid    (init_valid),
        .InitAddr     (init_addr),
        .InitData     (init_data),
        .InitReady    (init_ready),
        .Clear        (clear),
        .Busy         (busy),
        .DebugSelect  (dbg_sel),
        .DebugData    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic obs_req = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: consumes one scoreboard entry per requested observation.
    always @(negedge clk) begin
        if (obs_req) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_mem)  check({e.name, ".mem"},  mem_data, e.mem);
                if (e.chk_dbg)  check({e.name, ".dbg"},  dbg_data, e.dbg);
                if (e.chk_busy) check({e.name, ".busy"}, {7'd0, busy}, {7'd0, e.busy});
                if (e.chk_rdy)  check({e.name, ".rdy"},  {7'd0, init_ready}, {7'd0, e.rdy});
            end
        end
    end

    // Negative arguments mean "don't check this output".
    task automatic expect_obs(input string name, input int mem, input int dbg,
                              input int bsy, input int rdy);
        exp_t e;
        e.name     = name;
        e.chk_mem  = (mem >= 0);
        e.mem      = 8'(mem);
        e.chk_dbg  = (dbg >= 0);
        e.dbg      = 8'(dbg);
        e.chk_busy = (bsy >= 0);
        e.busy     = 1'(bsy);
        e.chk_rdy  = (rdy >= 0);
        e.rdy      = 1'(rdy);
        sb.push_back(e);
        obs_req = 1'b1;
        @(negedge clk);
        #2;
        obs_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exec_write(input logic [M-1:0] a, input logic [N-1:0] v);
        rw      = 1'b1;
        sel     = a;
        drv_val = v;
        tick();
        rw      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] cell_init [4];
        cell_init[0] = 8'h11;
        cell_init[1] = 8'h22;
        cell_init[2] = 8'h33;
        cell_init[3] = 8'h44;

        rst_n      = 1'b0;
        sel        = '0;
        rw         = 1'b0;
        drv_val    = '0;
        init_valid = 1'b0;
        init_addr  = '0;
        init_data  = '0;
        clear      = 1'b0;
        dbg_sel    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        sel = 2'd2;
        expect_obs("reset_read", 8'h00, 8'h00, 0, 1);
        tick();

        // Write then read back on bus and debug port
        exec_write(2'd1, 8'h5A);
        sel     = 2'd1;
        dbg_sel = 2'd1;
        expect_obs("write_read", 8'h5A, 8'h5A, 0, 1);
        tick();

        // Preload held off by an executor write, accepted the next cycle
        init_valid = 1'b1;
        init_addr  = 2'd3;
        init_data  = 8'h33;
        rw         = 1'b1;
        sel        = 2'd0;
        drv_val    = 8'h11;
        dbg_sel    = 2'd3;
        expect_obs("preload_blocked", -1, 8'h00, 0, 0);
        tick();
        rw  = 1'b0;
        sel = 2'd0;
        expect_obs("exec_priority", 8'h11, 8'h00, 0, 1);
        tick();
        init_valid = 1'b0;
        expect_obs("preload_done", 8'h11, 8'h33, 0, 1);
        tick();

        // Clear sweep over 11,22,33,44; a second Clear mid-sweep is ignored
        for (int i = 0; i < 4; i++) exec_write(M'(i), cell_init[i]);
        sel     = 2'd2;
        dbg_sel = 2'd3;
        expect_obs("sweep_preset", 8'h33, 8'h44, 0, 1);
        tick();
        clear = 1'b1;
        expect_obs("clear_pulse", -1, -1, 0, 1);
        tick();
        clear = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) clear = 1'b1;
            dbg_sel = (k < 2) ? 2'd0 : 2'd3;
            // cell0 cleared at the end of the first sweep cycle; cell3 at the end of the last
            expect_obs($sformatf("sweep_cycle%0d", k), -1,
                       (k == 0) ? 8'h11 : ((k == 1) ? 8'h00 : 8'h44), 1, 0);
            tick();
            clear = 1'b0;
        end
        expect_obs("sweep_end", -1, -1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = M'(i);
            expect_obs($sformatf("swept_cell%0d", i), -1, 8'h00, 0, 1);
        end
        tick();

        // Executor write lands on the same cycle the sweep clears cell2
        exec_write(2'd2, 8'h77);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        tick();
        rw      = 1'b1;
        sel     = 2'd2;
        drv_val = 8'hAB;
        expect_obs("collision_window", -1, -1, 1, 0);
        tick();
        rw      = 1'b0;
        dbg_sel = 2'd2;
        expect_obs("collision_kept", 8'hAB, 8'hAB, 1, 0);
        tick();
        dbg_sel = 2'd1;
        expect_obs("collision_done", 8'hAB, 8'h00, 0, 1);
        tick();

        // Asynchronous reset while the sweep is at index 1
        exec_write(2'd1, 8'h99);
        exec_write(2'd3, 8'h55);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        #2;
        rst_n   = 1'b0;
        dbg_sel = 2'd3;
        expect_obs("rst_mid_sweep", -1, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            dbg_sel = M'(i);
            expect_obs($sformatf("rst_cell%0d", i), -1, 8'h00, 0, 0);
        end
        tick();
        rst_n = 1'b1;
        sel     = 2'd1;
        dbg_sel = 2'd1;
        expect_obs("post_reset", 8'h00, 8'h00, 0, 1);
        tick();

        @(negedge clk);
        #1;
        check("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
